multibyte_add_ctrl: RTL and testbench
=====================================

# multibyte_add_ctrl

Sequencer that performs NBYTES-wide additions by time-multiplexing a single 8-bit ripple adder, one byte per clock, LSB first, with the carry chained through a register. It sits between an operand producer and a result consumer, both on valid/ready handshakes. It lets wide arithmetic reuse the team's existing 8-bit adder instead of building a wide one.

## Interface
- NBYTES, 4: operand width in bytes; legal range 2..16; W = 8*NBYTES
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand offer
- in_ready  out  1  block can accept operands
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_cin  in  1  carry into byte 0
- in_sub  in  1  subtract request (present only with MBADD_SUB_EN)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  W  result
- out_cout  out  1  carry out of the top byte
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch A, B, and the carry register (cin); clear idx; go RUN.
- RUN: adder inputs are A[idx], B[idx], carry. Each edge writes the adder sum into sum byte idx and updates carry from adder carry-out. idx increments. On the edge where idx==NBYTES-1, go DONE.
- DONE: out_valid=1. out_sum and out_cout hold stable. On out_valid&out_ready, go IDLE.
- in_ready=0 in RUN and DONE. in_a, in_b, and in_cin are ignored outside the accept edge.
- idx width: $clog2(NBYTES). No wrap occurs, because the terminal compare on NBYTES-1 ends RUN.
- Arithmetic is modulo 2^W. out_cout is the final carry, so {out_cout,out_sum} = A+B+cin exactly.
- Reset (async, any state): state=IDLE, idx=0, carry=0, out_sum=0, out_cout=0, out_valid=0, busy=0. in_ready reads 1 after reset deasserts. No capture occurs while rst_n is low.
- Reset during RUN or DONE discards the operation; no partial result is presented.

## Timing
- Accept on edge E0. The RUN edges are E1..EN. out_valid is high from EN; out_sum is final at EN.
- Latency from accept edge to out_valid: NBYTES cycles.
- With out_ready held high, the result transfers at EN+1 and the next accept can occur at EN+2. Peak throughput is one op per NBYTES+2 cycles.
- Back-pressure: DONE persists indefinitely while out_ready=0, with the result held.
- in_valid and out_ready may be asserted simultaneously with no interaction, because their states are disjoint.
- Registered outputs: out_sum, out_cout, out_valid, busy. in_ready is decoded from the state register only.

## Configuration
- MBADD_SUB_EN defined:
  - Adds the in_sub port.
  - When in_sub=1 at accept, B is latched as ~in_b and the carry register loads 1 (in_cin ignored). The result is A-B mod 2^W, and out_cout=1 means no borrow.
- MBADD_SUB_EN undefined:
  - No in_sub port and no inverter; addition only.

## Structure
- Shared package mbadd_pkg:
  - state enum (IDLE/RUN/DONE)
  - localparam function for the idx width
  - NBYTES legal-range constants, with an elaboration check
- One sub-module: the existing 8-bit adder (adder_8_bit), instantiated once as the datapath. The controller owns all registers; the adder stays purely combinational.

## Test plan
- Basic add, NBYTES=4:
  - Stimulus: A=0x000000FF, B=0x00000001, cin=0.
  - Response: out_sum=0x00000100, cout=0, out_valid exactly 4 cycles after the accept edge.
- Full carry ripple:
  - Stimulus: A=0xFFFFFFFF, B=0x00000000, cin=1.
  - Response: out_sum=0x00000000, cout=1.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
  - Response: out_sum and cout stable, in_ready=0 throughout. Transfer occurs on the first out_ready=1 edge, and in_ready=1 on the next cycle.
- Back-to-back ops:
  - Stimulus: in_valid and out_ready held high, 3 operand pairs.
  - Response: accepts spaced exactly 6 cycles apart, and results in order.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 at idx=2.
  - Response: all outputs 0 immediately. After release, in_ready=1 and the next op is correct with no stale carry.
- MBADD_SUB_EN:
  - Stimulus: A=0x00000005, B=0x00000007, in_sub=1.
  - Response: out_sum=0xFFFFFFFE, cout=0.
  - Stimulus: A=7, B=5.
  - Response: out_sum=0x00000002, cout=1.

Source files
------------

// File: rtl/mbadd_pkg.sv
// Shared types and constants for the byte-serial multi-byte adder.
package mbadd_pkg;

  localparam int NBYTES_MIN = 2;
  localparam int NBYTES_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int nbytes);
    return (nbytes <= 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/adder_8_bit.sv
// Purely combinational 8-bit ripple-carry adder.
module adder_8_bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < 8; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/multibyte_add_ctrl.sv
// NBYTES-wide add sequenced through one 8-bit adder, LSB byte first.
// Define MBADD_SUB_EN to add the in_sub port (A-B via ~B plus carry-in 1).
module multibyte_add_ctrl
  import mbadd_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
`ifdef MBADD_SUB_EN
  input  logic                  in_sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  busy
);

  localparam int IW = idx_w(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
    $error("multibyte_add_ctrl: NBYTES out of legal range");
  end

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q;
  logic [NBYTES-1:0][7:0]  a_q, b_q, sum_q;
  logic                    carry_q, vld_q, busy_q;
  logic [8*NBYTES-1:0]     b_in;
  logic                    cin_in;
  logic [7:0]              add_sum;
  logic                    add_cout;

`ifdef MBADD_SUB_EN
  assign b_in   = in_sub ? ~in_b : in_b;
  assign cin_in = in_sub ? 1'b1 : in_cin;
`else
  assign b_in   = in_b;
  assign cin_in = in_cin;
`endif

  adder_8_bit u_add (
    .a_i    (a_q[idx_q]),
    .b_i    (b_q[idx_q]),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN:     if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // idx stops at LAST rather than wrapping; it is cleared again on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= in_a;
          b_q     <= b_in;
          carry_q <= cin_in;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
        RUN: begin
          sum_q[idx_q] <= add_sum;
          carry_q      <= add_cout;
          if (idx_q == LAST) vld_q <= 1'b1;
          else               idx_q <= idx_q + 1'b1;
        end
        DONE: if (out_ready) begin
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = sum_q;
  assign out_cout  = carry_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Bench for multibyte_add_ctrl: timeline model plus directed literal vectors.
module tb_multibyte_add_ctrl;

  localparam int N = 4;
  localparam int W = 8 * N;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_cout, busy;
  logic [W-1:0] out_sum;

  multibyte_add_ctrl #(.NBYTES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef MBADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

`ifdef MBADD_SUB_EN
  wire sub_eff = in_sub;
`else
  wire sub_eff = 1'b0;
`endif

  function automatic logic [W:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  // Model: an op is in flight from accept until transfer; result shows N edges after accept.
  int         cyc = 0;
  logic       m_busy = 1'b0;
  int         m_acc = 0;
  logic [W:0] m_exp = '0;
  int         acc_log[$];
  logic [W:0] dut_res[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
    end else if (!m_busy && in_valid) begin
      m_busy <= 1'b1;
      m_acc  <= cyc + 1;
      m_exp  <= ref_res(in_a, in_b, in_cin, sub_eff);
      acc_log.push_back(cyc);
    end else if (m_busy && (cyc - m_acc >= N) && out_ready) begin
      m_busy <= 1'b0;
      dut_res.push_back({out_cout, out_sum});
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy",  64'(busy),      64'd0);
      chk("rst_sum",   64'(out_sum),   64'd0);
      chk("rst_cout",  64'(out_cout),  64'd0);
    end else begin
      chk("m_ready", 64'(in_ready),  64'(!m_busy));
      chk("m_busy",  64'(busy),      64'(m_busy));
      chk("m_valid", 64'(out_valid), 64'(m_busy && (cyc - m_acc >= N)));
      if (m_busy && (cyc - m_acc >= N))
        chk("m_result", 64'({out_cout, out_sum}), 64'(m_exp));
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 64'(t), 64'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input logic [W-1:0] e_sum, input logic e_cout,
                        input int hold);
    int lat;
    @(negedge clk);
    wait_ready();
    in_a = a; in_b = b; in_cin = c; in_sub = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(N));
    chk("sum", 64'(out_sum), 64'(e_sum));
    chk("cout", 64'(out_cout), 64'(e_cout));
    repeat (hold) begin
      @(negedge clk);
      chk("bp_sum",   64'(out_sum),   64'(e_sum));
      chk("bp_cout",  64'(out_cout),  64'(e_cout));
      chk("bp_ready", 64'(in_ready),  64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("xfer_valid", 64'(out_valid), 64'd0);
    chk("xfer_ready", 64'(in_ready),  64'd1);
  endtask

  logic [W-1:0] bb_a[3]   = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [W-1:0] bb_b[3]   = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
  logic         bb_c[3]   = '{1'b0, 1'b1, 1'b0};
  logic [W:0]   bb_exp[3] = '{33'h0_0000_0003, 33'h1_FFFF_FFFF, 33'h0_0001_0000};

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(in_ready), 64'd1);
    #2 rst_n = 1'b1;

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 0);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 10);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 3);

    // Back-to-back with both handshakes held open.
    acc_log.delete();
    dut_res.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_a = bb_a[k]; in_b = bb_b[k]; in_cin = bb_c[k]; in_sub = 1'b0; in_valid = 1'b1;
      wait_ready();
      @(negedge clk);
    end
    in_valid = 1'b0;
    t = 0;
    while (dut_res.size() < 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    chk("b2b_accepts", 64'(acc_log.size()), 64'd3);
    chk("b2b_results", 64'(dut_res.size()), 64'd3);
    if (acc_log.size() == 3) begin
      chk("b2b_gap0", 64'(acc_log[1] - acc_log[0]), 64'd6);
      chk("b2b_gap1", 64'(acc_log[2] - acc_log[1]), 64'd6);
    end
    for (int k = 0; k < 3; k++)
      if (k < dut_res.size()) chk("b2b_order", 64'(dut_res[k]), 64'(bb_exp[k]));

    // Reset while the adder is on byte 2.
    @(negedge clk);
    in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy",  64'(busy),      64'd0);
    chk("midrst_sum",   64'(out_sum),   64'd0);
    chk("midrst_cout",  64'(out_cout),  64'd0);
    chk("midrst_ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 64'(in_ready), 64'd1);
    run_op(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 0);

`ifdef MBADD_SUB_EN
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 0);
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
